// File: rtl/imem_loader_if.sv
// Byte-stream handshake from the host link plus the instruction-memory
// write port, bundled so the loader and its neighbours share one bus.
interface imem_loader_if #(
    parameter int ADDR_W = 10
);
    logic              s_valid;
    logic [7:0]        s_data;
    logic              s_ready;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [31:0]       wdata;

    // Loader side: consumes host bytes, drives the memory write port.
    modport slave (
        input  s_valid, s_data,
        output s_ready, we, waddr, wdata
    );

    // Host/memory side: produces bytes, observes writes.
    modport master (
        output s_valid, s_data,
        input  s_ready, we, waddr, wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: parses a big-endian word count followed by big-endian words,
// writes them into instruction memory and releases the CPU reset on success.
module imem_loader #(
    parameter int ADDR_W = 10
) (
    input  logic          clk,
    input  logic          rst,
    imem_loader_if.slave  bus,
    output logic          cpu_rst,
    output logic          done,
    output logic          err
);
    typedef enum logic [1:0] {S_LEN, S_DATA, S_WRITE, S_DONE} state_t;

    state_t            r_state, w_state_next;
    logic [31:0]       r_len, w_len_next;
    logic [23:0]       r_word, w_word_next;
    logic [1:0]        r_cnt, w_cnt_next;
    logic [ADDR_W:0]   r_idx, w_idx_next;
    logic              r_ready, w_ready_next;
    logic              r_we, w_we_next;
    logic [ADDR_W-1:0] r_waddr, w_waddr_next;
    logic [31:0]       r_wdata, w_wdata_next;
    logic              r_cpu_rst, w_cpu_rst_next;
    logic              r_done, w_done_next;
    logic              r_err, w_err_next;

    logic              w_fire;
    logic [31:0]       w_len_shift;
    logic [31:0]       w_word_full;
    logic [ADDR_W:0]   w_idx_inc;
    logic              w_len_over;

    assign w_fire      = bus.s_valid && r_ready;
    assign w_len_shift = {r_len[23:0], bus.s_data};
    assign w_word_full = {r_word, bus.s_data};
    assign w_idx_inc   = r_idx + (ADDR_W+1)'(1);
    // Word index is one bit wider than waddr so a full-capacity image is legal.
    assign w_len_over  = {1'b0, w_len_shift} > (33'd1 << ADDR_W);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_LEN;
            r_len     <= '0;
            r_word    <= '0;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_ready   <= 1'b1;
            r_we      <= 1'b0;
            r_waddr   <= '0;
            r_wdata   <= '0;
            r_cpu_rst <= 1'b1;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_len     <= w_len_next;
            r_word    <= w_word_next;
            r_cnt     <= w_cnt_next;
            r_idx     <= w_idx_next;
            r_ready   <= w_ready_next;
            r_we      <= w_we_next;
            r_waddr   <= w_waddr_next;
            r_wdata   <= w_wdata_next;
            r_cpu_rst <= w_cpu_rst_next;
            r_done    <= w_done_next;
            r_err     <= w_err_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_len_next     = r_len;
        w_word_next    = r_word;
        w_cnt_next     = r_cnt;
        w_idx_next     = r_idx;
        w_we_next      = 1'b0;
        w_waddr_next   = r_waddr;
        w_wdata_next   = r_wdata;
        w_cpu_rst_next = r_cpu_rst;
        w_done_next    = r_done;
        w_err_next     = r_err;

        case (r_state)
            S_LEN: begin
                if (w_fire) begin
                    w_len_next = w_len_shift;
                    w_cnt_next = r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        if (w_len_shift == 32'd0) begin
                            w_state_next   = S_DONE;
                            w_done_next    = 1'b1;
                            w_cpu_rst_next = 1'b0;
                        end else if (w_len_over) begin
                            w_state_next = S_DONE;
                            w_done_next  = 1'b1;
                            w_err_next   = 1'b1;
                        end else begin
                            w_state_next = S_DATA;
                        end
                    end
                end
            end
            S_DATA: begin
                if (w_fire) begin
                    w_word_next = w_word_full[23:0];
                    w_cnt_next  = r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        w_state_next = S_WRITE;
                        w_we_next    = 1'b1;
                        w_waddr_next = r_idx[ADDR_W-1:0];
                        w_wdata_next = w_word_full;
                    end
                end
            end
            S_WRITE: begin
                w_idx_next = w_idx_inc;
                if (32'(w_idx_inc) == r_len) begin
                    w_state_next   = S_DONE;
                    w_done_next    = 1'b1;
                    w_cpu_rst_next = 1'b0;
                end else begin
                    w_state_next = S_DATA;
                end
            end
            default: begin
                w_state_next = S_DONE;
            end
        endcase

        w_ready_next = (w_state_next == S_LEN) || (w_state_next == S_DATA);
    end

    assign bus.s_ready = r_ready;
    assign bus.we      = r_we;
    assign bus.waddr   = r_waddr;
    assign bus.wdata   = r_wdata;
    assign cpu_rst     = r_cpu_rst;
    assign done        = r_done;
    assign err         = r_err;
endmodule

// File: tb/tb_imem_loader.sv
// Randomized and directed bench for imem_loader: a byte-count model of the
// image format predicts every output cycle by cycle; literal checks pin it.
module tb_imem_loader;
    localparam int AW  = 2;
    localparam int CAP = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cpu_rst, done, err;

    imem_loader_if #(.ADDR_W(AW)) bus ();

    imem_loader #(.ADDR_W(AW)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .cpu_rst (cpu_rst),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct {
        int          addr;
        logic [31:0] data;
        int          c;
    } wr_t;
    wr_t wlog[$];
    int  done_cyc;

    // Model: everything follows from how many bytes have been accepted.
    bit          m_live = 0;
    int          m_nb;
    logic [31:0] m_shift, m_len, m_wword;
    bit          m_done, m_err, m_wr;
    int          m_widx;
    logic        prev_done = 1'b0;

    always @(negedge clk) begin
        if (m_live) begin
            chk("s_ready", bus.s_ready, !m_done && !m_wr);
            chk("we", bus.we, m_wr);
            chk("done", done, m_done);
            chk("err", err, m_err);
            chk("cpu_rst", cpu_rst, !(m_done && !m_err));
            if (m_wr) begin
                chk("waddr", bus.waddr, m_widx[AW-1:0]);
                chk("wdata", bus.wdata, m_wword);
            end
        end
        if (bus.we === 1'b1) begin
            wlog.push_back('{int'(bus.waddr), bus.wdata, cyc});
            $display("write addr=%0d data=%08h cycle=%0d", bus.waddr, bus.wdata, cyc);
        end
        if (done === 1'b1 && prev_done !== 1'b1) done_cyc = cyc;
        prev_done = done;

        if (rst) begin
            m_live = 1; m_nb = 0; m_shift = '0; m_len = '0;
            m_done = 0; m_err = 0; m_wr = 0; m_widx = 0; m_wword = '0;
        end else if (m_live) begin
            if (m_wr) begin
                m_wr = 0;
                if (m_widx + 1 == int'(m_len)) m_done = 1;
            end else if (!m_done && bus.s_valid) begin
                m_nb++;
                m_shift = {m_shift[23:0], bus.s_data};
                if (m_nb == 4) begin
                    m_len = m_shift;
                    if (m_len == 0) m_done = 1;
                    else if (m_len > CAP) begin m_done = 1; m_err = 1; end
                end else if (m_nb > 4 && (m_nb - 4) % 4 == 0) begin
                    m_wr    = 1;
                    m_widx  = (m_nb - 4) / 4 - 1;
                    m_wword = m_shift;
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_s_ready", bus.s_ready, 1'b1);
        chk("rst_we", bus.we, 1'b0);
        chk("rst_waddr", bus.waddr, 0);
        chk("rst_wdata", bus.wdata, 0);
        chk("rst_cpu_rst", cpu_rst, 1'b1);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        wlog.delete();
    endtask

    // Leaves s_valid high after the transfer so WRITE cycles see a waiting byte.
    task automatic send_byte(input logic [7:0] b, input int gap_max);
        int g;
        int t;
        g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
        if (g > 0) begin
            bus.s_valid = 1'b0;
            repeat (g) begin @(posedge clk); #1; end
        end
        bus.s_valid = 1'b1;
        bus.s_data  = b;
        t = 0;
        forever begin
            @(negedge clk);
            if (bus.s_ready) break;
            t++;
            if (t > 50) begin
                chk("send_timeout", 0, 1);
                return;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap_max);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], gap_max);
    endtask

    task automatic wait_done();
        int t = 0;
        while (done !== 1'b1 && t < 100) begin @(posedge clk); #1; t++; end
        chk("done_timeout", done, 1'b1);
        bus.s_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
    endtask

    logic [31:0] img[$];

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;

        // Normal load, s_valid constantly high
        do_reset();
        img = '{32'h20080005, 32'h2009000C, 32'h01095020};
        send_word(32'd3, 0);
        foreach (img[i]) send_word(img[i], 0);
        wait_done();
        chk("n_writes", wlog.size(), 3);
        if (wlog.size() == 3) begin
            chk("w0_addr", wlog[0].addr, 0); chk("w0_data", wlog[0].data, 32'h20080005);
            chk("w1_addr", wlog[1].addr, 1); chk("w1_data", wlog[1].data, 32'h2009000C);
            chk("w2_addr", wlog[2].addr, 2); chk("w2_data", wlog[2].data, 32'h01095020);
            chk("spacing01", wlog[1].c - wlog[0].c, 5);
            chk("spacing12", wlog[2].c - wlog[1].c, 5);
            chk("done_after_last", done_cyc - wlog[2].c, 1);
        end
        chk("normal_cpu_rst", cpu_rst, 1'b0);
        chk("normal_err", err, 1'b0);

        // Zero length; a following byte must stay unaccepted
        do_reset();
        send_word(32'd0, 0);
        bus.s_valid = 1'b1; bus.s_data = 8'hA5;
        repeat (4) begin @(posedge clk); #1; end
        chk("zero_s_ready", bus.s_ready, 1'b0);
        chk("zero_done", done, 1'b1);
        chk("zero_cpu_rst", cpu_rst, 1'b0);
        chk("zero_writes", wlog.size(), 0);
        bus.s_valid = 1'b0;

        // Overflow: 5 words into a 4-word memory
        do_reset();
        send_word(32'd5, 1);
        wait_done();
        chk("ovf_err", err, 1'b1);
        chk("ovf_cpu_rst", cpu_rst, 1'b1);
        chk("ovf_writes", wlog.size(), 0);

        // Exactly full capacity
        do_reset();
        send_word(32'd4, 1);
        for (int i = 0; i < 4; i++) send_word($urandom, 2);
        wait_done();
        chk("full_err", err, 1'b0);
        chk("full_writes", wlog.size(), 4);
        foreach (wlog[i]) chk("full_addr", wlog[i].addr, i);

        // Reset mid-word, then reload
        do_reset();
        send_word(32'd2, 0);
        send_word(32'h11223344, 0);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        bus.s_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("midword_writes", wlog.size(), 1);
        do_reset();
        send_word(32'd1, 1);
        send_word(32'hAC080050, 1);
        wait_done();
        chk("reload_writes", wlog.size(), 1);
        if (wlog.size() == 1) begin
            chk("reload_addr", wlog[0].addr, 0);
            chk("reload_data", wlog[0].data, 32'hAC080050);
        end
        chk("reload_cpu_rst", cpu_rst, 1'b0);

        // Random images with random gaps and occasional aborts
        for (int it = 0; it < 25; it++) begin
            int n, cut, total, sent;
            n     = $urandom_range(0, CAP + 1);
            total = 4 + ((n <= CAP) ? 4 * n : 0);
            cut   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, total)) : total + 1;
            do_reset();
            img.delete();
            for (int i = 0; i < n; i++) img.push_back($urandom);
            sent = 0;
            for (int i = 3; i >= 0 && sent < cut; i--) begin
                send_byte(8'(n >> (i * 8)), 3); sent++;
            end
            for (int w = 0; w < n && n <= CAP; w++)
                for (int i = 3; i >= 0 && sent < cut; i--) begin
                    send_byte(img[w][i*8 +: 8], 3); sent++;
                end
            if (cut > total) begin
                wait_done();
                chk("rand_writes", wlog.size(), (n <= CAP) ? n : 0);
                foreach (wlog[i]) if (i < img.size()) chk("rand_data", wlog[i].data, img[i]);
            end else begin
                bus.s_valid = 1'b0;
                @(posedge clk); #1;
            end
        end

        do_reset();
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
